// File: rtl/kpd_pkg.sv
// Shared types for the hex keypad entry block: key map, debounce FSM states, frame classes.
// Pure declarations; no logic, no latency.
package kpd_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_DEB, ST_HELD, ST_REL} kpd_state_t;

  typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} frame_cls_t;

  // Indexed by row*4 + col.
  localparam logic [3:0] KEYMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

endpackage

// File: rtl/kpd_col_scanner.sv
// Column scanner: drives one column low per SCAN_DIV-cycle slot, samples synced rows at slot end,
// and flags each 4-column frame with its class/code one cycle after the last sample; never stalls.
module kpd_col_scanner
  import kpd_pkg::*;
#(
  parameter int SCAN_DIV = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       frame_evt,
  output frame_cls_t frame_cls,
  output logic [3:0] frame_code
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);

  logic [3:0]    row_s1;
  logic [3:0]    row_s2;
  logic [SW-1:0] slot;
  logic [1:0]    col_idx;
  logic [3:0]    smp [4];
  logic [4:0]    low_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1    <= 4'hF;
      row_s2    <= 4'hF;
      slot      <= '0;
      col_idx   <= 2'd0;
      frame_evt <= 1'b0;
      for (int c = 0; c < 4; c++) smp[c] <= 4'hF;
    end else begin
      row_s1    <= row;
      row_s2    <= row_s1;
      frame_evt <= 1'b0;
      if (slot == SLOT_LAST) begin
        // Sample at the end of the slot so the rows have settled after the column switch.
        slot         <= '0;
        smp[col_idx] <= row_s2;
        col_idx      <= col_idx + 2'd1;
        if (col_idx == 2'd3) frame_evt <= 1'b1;
      end else begin
        slot <= slot + 1'b1;
      end
    end
  end

  assign col = ~(4'b0001 << col_idx);

  always_comb begin
    low_cnt    = 5'd0;
    frame_code = 4'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!smp[c][r]) begin
          low_cnt    = low_cnt + 5'd1;
          frame_code = KEYMAP[r*4 + c];
        end
      end
    end
    if (low_cnt == 5'd0)      frame_cls = CLS_NONE;
    else if (low_cnt == 5'd1) frame_cls = CLS_SINGLE;
    else                      frame_cls = CLS_MULTI;
  end

endmodule

// File: rtl/hex_keypad_entry.sv
// Hex keypad entry: scans a 4x4 keypad, debounces per frame, shifts accepted digits into a 16-bit word.
// key_pulse one cycle after the DEBOUNCE-th matching frame ends; free-running, no backpressure.
module hex_keypad_entry
  import kpd_pkg::*;
#(
  parameter int SCAN_DIV = 10000,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  input  logic        clr,
  output logic [3:0]  col,
  output logic [15:0] value,
  output logic [3:0]  key_code,
  output logic        key_pulse,
  output logic        key_down
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE);
  localparam logic [DW-1:0] DCNT_ONE  = DW'(1);

  logic       frame_evt;
  frame_cls_t frame_cls;
  logic [3:0] frame_code;

  kpd_state_t    state;
  logic [3:0]    cand;
  logic [DW-1:0] dcnt;
  logic [DW-1:0] dcnt_nxt;

  kpd_col_scanner #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk        (clk),
    .rst        (rst),
    .row        (row),
    .col        (col),
    .frame_evt  (frame_evt),
    .frame_cls  (frame_cls),
    .frame_code (frame_code)
  );

  assign dcnt_nxt = dcnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cand      <= 4'h0;
      dcnt      <= '0;
      value     <= 16'h0000;
      key_code  <= 4'h0;
      key_pulse <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      key_pulse <= 1'b0;
      if (clr) value <= 16'h0000;
      if (frame_evt) begin
        case (state)
          ST_IDLE: begin
            if (frame_cls == CLS_SINGLE) begin
              state <= ST_DEB;
              cand  <= frame_code;
              dcnt  <= DCNT_ONE;
            end
          end
          ST_DEB: begin
            if (frame_cls == CLS_SINGLE && frame_code == cand) begin
              if (dcnt_nxt == DCNT_LAST) begin
                state     <= ST_HELD;
                key_pulse <= 1'b1;
                key_code  <= cand;
                key_down  <= 1'b1;
                // A coincident clear wipes the old digits but keeps the new one.
                value     <= clr ? {12'h000, cand} : {value[11:0], cand};
              end else begin
                dcnt <= dcnt_nxt;
              end
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_HELD: begin
            if (frame_cls == CLS_NONE) begin
              state <= ST_REL;
              dcnt  <= DCNT_ONE;
            end
          end
          ST_REL: begin
            if (frame_cls == CLS_NONE) begin
              if (dcnt_nxt == DCNT_LAST) begin
                state    <= ST_IDLE;
                key_down <= 1'b0;
              end else begin
                dcnt <= dcnt_nxt;
              end
            end else begin
              state <= ST_HELD;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Bench for hex_keypad_entry: frame-aligned keypad stimulus, press-level reference model, pulse scoreboard.
module tb_hex_keypad_entry;

  localparam int DEB = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row;
  logic        clr;
  logic [3:0]  col;
  logic [15:0] value;
  logic [3:0]  key_code;
  logic        key_pulse;
  logic        key_down;

  logic [15:0] pressed;

  hex_keypad_entry #(.SCAN_DIV(4), .DEBOUNCE(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .clr       (clr),
    .col       (col),
    .value     (value),
    .key_code  (key_code),
    .key_pulse (key_pulse),
    .key_down  (key_down)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key shorts its row to its column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col[c] && pressed[r*4 + c]) row[r] = 1'b0;
  end

  logic [3:0] km [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                          4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};

  typedef struct {
    logic [3:0]  code;
    logic [15:0] val;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Reference model: a press counts once the keypad has been quiet for DEB frames and
  // the same lone key is then seen for DEB consecutive frames.
  bit          armed;
  int          run;
  logic [3:0]  run_key;
  int          quiet;
  logic [15:0] m_value;
  bit          have_prev;
  logic [15:0] prev_mask;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] key_mask(input logic [3:0] code);
    logic [15:0] m = 16'h0;
    for (int i = 0; i < 16; i++) if (km[i] == code) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [3:0] mask_code(input logic [15:0] m);
    logic [3:0] k = 4'h0;
    for (int i = 0; i < 16; i++) if (m[i]) k = km[i];
    return k;
  endfunction

  task automatic model_reset();
    armed = 1; run = 0; run_key = 4'h0; quiet = 0; m_value = 16'h0;
    have_prev = 0; prev_mask = 16'h0;
  endtask

  task automatic model_frame(input logic [15:0] m, input bit do_clr);
    int   n   = $countones(m);
    logic [3:0] k = mask_code(m);
    bit   acc = 0;
    if (armed) begin
      if (run == 0) begin
        if (n == 1) begin run = 1; run_key = k; end
      end else if (n == 1 && k == run_key) begin
        run++;
        if (run == DEB) begin acc = 1; armed = 0; quiet = 0; run = 0; end
      end else begin
        run = 0;
      end
    end else if (n == 0) begin
      quiet++;
      if (quiet == DEB) begin armed = 1; run = 0; end
    end else begin
      quiet = 0;
    end
    if (acc) begin
      m_value = do_clr ? {12'h000, run_key} : {m_value[11:0], run_key};
      exp_q.push_back('{code: run_key, val: m_value});
    end else if (do_clr) begin
      m_value = 16'h0;
    end
  endtask

  // One 16-cycle scan frame, starting mid-way through the col0 slot.
  task automatic frame(input logic [15:0] m, input bit do_clr);
    if (have_prev) model_frame(prev_mask, do_clr);
    else if (do_clr) m_value = 16'h0;
    pressed = m;
    clr     = do_clr;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    chk("value", 32'(value), 32'(m_value));
    chk("key_down", 32'(key_down), 32'(!armed));
    repeat (14) @(negedge clk);
    prev_mask = m;
    have_prev = 1;
  endtask

  task automatic press(input logic [3:0] code, input int hold, input int rel);
    for (int i = 0; i < hold; i++) frame(key_mask(code), 1'b0);
    for (int i = 0; i < rel; i++) frame(16'h0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_col", 32'(col), 32'hE);
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_code", 32'(key_code), 32'h0);
    chk("rst_pulse", 32'(key_pulse), 32'h0);
    chk("rst_down", 32'(key_down), 32'h0);
    model_reset();
    rst = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && key_pulse) begin
        pulses++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pulse_unexpected: key_code=%h value=%h, expected no pulse", key_code, value);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_code", 32'(key_code), 32'(e.code));
          chk("pulse_value", 32'(value), 32'(e.val));
          chk("pulse_down", 32'(key_down), 32'h1);
        end
      end
    end
  endtask

  logic [3:0]  seq_keys [5] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'hB};
  logic [15:0] seq_vals [5] = '{16'h0001, 16'h0012, 16'h0123, 16'h123A, 16'h23AB};

  initial begin
    int          p0;
    logic [15:0] rm;
    logic [15:0] last;
    logic [3:0]  exp_col;
    fork
      monitor();
    join_none
    pressed = 16'h0;
    clr     = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 32; i++) begin
      exp_col = ~(4'b0001 << ((i / 4) % 4));
      chk("col_seq", 32'(col), 32'(exp_col));
      @(negedge clk);
    end
    have_prev = 1;
    prev_mask = 16'h0;

    p0 = pulses;
    press(4'h5, 3, 3);
    chk("k5_pulses", 32'(pulses - p0), 32'd1);
    chk("k5_code", 32'(key_code), 32'h5);
    chk("k5_value", 32'(value), 32'h0005);

    frame(16'h0, 1'b1);
    chk("clr_value", 32'(value), 32'h0000);
    for (int i = 0; i < 5; i++) begin
      press(seq_keys[i], 2, 2);
      chk("seq_value", 32'(value), 32'(seq_vals[i]));
    end

    p0 = pulses;
    for (int i = 0; i < 3; i++) begin
      frame(key_mask(4'h7), 1'b0);
      frame(16'h0, 1'b0);
    end
    for (int i = 0; i < 4; i++) frame(key_mask(4'h8) | key_mask(4'hC), 1'b0);
    frame(16'h0, 1'b0);
    frame(16'h0, 1'b0);
    chk("bounce_multi_pulses", 32'(pulses - p0), 32'd0);

    frame(16'h0, 1'b1);
    press(4'h1, 2, 2);
    press(4'h2, 2, 2);
    press(4'h3, 2, 2);
    press(4'h4, 2, 2);
    chk("pre_f_value", 32'(value), 32'h1234);
    frame(key_mask(4'hF), 1'b0);
    frame(key_mask(4'hF), 1'b0);
    frame(16'h0, 1'b1);
    chk("clr_accept_value", 32'(value), 32'h000F);
    frame(16'h0, 1'b0);
    frame(16'h0, 1'b1);
    chk("clr_alone_value", 32'(value), 32'h0000);

    for (int i = 0; i < 3; i++) frame(key_mask(4'hD), 1'b0);
    do_reset();
    p0 = pulses;
    for (int i = 0; i < 3; i++) frame(key_mask(4'hD), 1'b0);
    chk("rst_d_pulses", 32'(pulses - p0), 32'd1);
    chk("rst_d_value", 32'(value), 32'h000D);
    frame(16'h0, 1'b0);
    frame(16'h0, 1'b0);

    last = 16'h0;
    for (int i = 0; i < 150; i++) begin
      int r = $urandom_range(0, 99);
      if (r < 55)      rm = last;
      else if (r < 75) rm = 16'h0;
      else if (r < 93) rm = 16'h1 << $urandom_range(0, 15);
      else             rm = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      last = rm;
      frame(rm, $urandom_range(0, 19) == 0);
    end
    frame(16'h0, 1'b0);
    frame(16'h0, 1'b0);
    frame(16'h0, 1'b0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
